bch_syndrome_stream: RTL and testbench
======================================

# bch_syndrome_stream

Front-end control stage of the BCH decoder. It accepts a received codeword as a serial bit stream under a valid/ready handshake and drives a bank of T per-syndrome Horner accumulators (start/ce/data_in). After N = 2^M−1 bits it snapshots all T syndromes into a held output register and presents them downstream to the error-locator stage under a second valid/ready handshake. The next codeword streams in while the previous syndromes wait; the block stalls only when the output register is still occupied.

## Interface

- M, default 4: GF(2^M) field width. Codeword length N = 2^M−1.
- T, default 3: correctable errors. T syndromes are computed, index i = 0..T−1, syndrome power j = idx2syn(M, i).
- clk, in, 1: clock. All state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- data_valid, in, 1: data_in is presented.
- data_ready, out, 1: the block accepts data_in this cycle. A bit transfers when data_valid && data_ready.
- data_in, in, 1: received bit. The first bit of a codeword is r_(N−1) and the last is r_0.
- syn_valid, out, 1: syn_out and syn_zero hold a completed codeword.
- syn_ready, in, 1: downstream consumes the output. A transfer occurs when syn_valid && syn_ready.
- syn_out, out, T*M: syndrome i occupies bits [i*M +: M], in standard basis (bit 0 is the α^0 coefficient).
- syn_zero, out, 1: all T syndromes are zero (no detectable error).

## Operation

- The bit counter cnt runs 0..N−1 and is ceil(log2 N) bits wide. It counts accepted bits of the current codeword.
- Per accepted bit:
  - When cnt == 0, pulse start to all accumulators.
  - Otherwise, pulse ce to all accumulators.
  - data_in is forwarded unchanged.
  - The accumulators are never clocked on cycles without a transfer.
- cnt behaviour:
  - Increments on each accepted bit.
  - On the accepted bit with cnt == N−1, cnt wraps to 0 and the state goes RUN→FLUSH.
- State machine, states RUN and FLUSH:
  - RUN: data_ready = 1.
  - FLUSH: the snapshot may happen when the output is free, meaning !syn_valid || syn_ready.
    - If free: capture syn_out ← accumulator values and syn_zero ← (all syndromes == 0), set syn_valid ← 1, return to RUN. data_ready = 1 in this cycle. A bit accepted in the same cycle asserts start, which is safe because the snapshot samples the pre-edge accumulator values.
    - If not free: data_ready = 0, stay in FLUSH.
- syn_valid behaviour:
  - Clears on an output transfer unless a snapshot occurs in the same cycle.
  - If both happen in the same cycle, the snapshot wins and syn_valid stays 1.
- syn_out and syn_zero are stable while syn_valid && !syn_ready.
- Reset values: state RUN, cnt 0, syn_valid 0, syn_out 0, syn_zero 0. data_ready reads 1 immediately after reset.
- Reset mid-codeword discards the partial codeword. The accumulators need no reset because the next accepted bit asserts start.

## Timing

- Latency: the last bit is accepted at edge E. With the output free, syn_valid rises after edge E+1.
- Throughput: one bit per cycle, sustained across codewords, with no bubble when syn_ready = 1. N bits take N cycles.
- Stall: the block holds in FLUSH for exactly as many cycles as the output stays occupied. data_ready is combinational on state, syn_valid and syn_ready.
- There are no combinational paths from data_valid or data_in to any output.

## Structure

- The shared header bch.vh provides lpow, idx2syn and the log2 helper used for the cnt width. No new package constants are needed.
- Sub-module: T instances of the existing per-syndrome method-1 accumulator (dsynN_method1), one per IDX = 0..T−1, in a generate loop.
- The counter, FSM, output register and zero-detect live in this module.

## Test plan

Common setup unless stated: M=4, T=3, primitive polynomial x^4+x+1, syn_ready = 1.

- **All-zero codeword.** Drive 15 zero bits, data_valid = 1 continuously. Required: syn_valid rises 2 edges after the first... precisely, after edge 16; syn_out = 0; syn_zero = 1.
- **Single error at r_0.** The 15th bit is 1, all others 0. Required: each syndrome field = 4'b0001; syn_zero = 0.
- **Single error at r_1.** The 14th bit is 1, all others 0. Required: S1 = 4'b0010, S3 = 4'b1000, S5 = 4'b0110, i.e. syn_out = 12'h682.
- **Back-to-back codewords.** Stream 30 bits: the r_1 error codeword, then the all-zero codeword. Required: data_ready never drops; two syn_valid results, 15 cycles apart, with the correct values for each.
- **Backpressure.** syn_ready = 0; stream two codewords. Required:
  - After the 30th bit, data_ready = 0 and the first codeword's syndromes are held unchanged.
  - Raise syn_ready for 1 cycle: the second codeword's syndromes load and data_ready returns to 1.
- **Reset mid-codeword.** Assert reset after 7 bits, then send a clean all-zero codeword. Required: syn_valid = 0 during and after reset until 15 new bits are accepted; result syn_zero = 1.

Source files
------------

// File: rtl/bch_syndrome_stream_pkg.sv
// Shared BCH helpers: FSM state type, syndrome index mapping, primitive
// polynomials per field width and a ceil(log2) helper for counter sizing.
package bch_syndrome_stream_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Syndrome i of a narrow-sense binary BCH code is S_(2i+1); even powers are redundant.
    function automatic int unsigned idx2syn(input int unsigned idx);
        return 2 * idx + 1;
    endfunction

    // Primitive polynomial low-order coefficients (the x^M term is implicit).
    function automatic int unsigned prim_poly(input int unsigned m);
        case (m)
            3:       return 32'h03; // x^3+x+1
            4:       return 32'h03; // x^4+x+1
            5:       return 32'h05; // x^5+x^2+1
            6:       return 32'h03; // x^6+x+1
            7:       return 32'h09; // x^7+x^3+1
            8:       return 32'h1D; // x^8+x^4+x^3+x^2+1
            default: return 32'h03;
        endcase
    endfunction

    // Ceiling log2, minimum result 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bch_syndrome_stream_acc.sv
// Per-syndrome Horner accumulator over GF(2^M): S <- S*alpha^J + r.
// Ports: clk; start loads data_in as a fresh accumulation; ce folds in the
// next bit; syn is the running syndrome in standard basis.
module bch_syndrome_stream_acc
    import bch_syndrome_stream_pkg::*;
#(
    parameter int unsigned M   = 4,
    parameter int unsigned IDX = 0
) (
    input  logic         clk,
    input  logic         start,
    input  logic         ce,
    input  logic         data_in,
    output logic [M-1:0] syn
);

    localparam int unsigned   J    = idx2syn(IDX);
    localparam logic [M-1:0] POLY = M'(prim_poly(M));

    logic [M-1:0] syn_q;
    logic [M-1:0] syn_d;
    logic [M-1:0] scaled;

    // Multiply the running value by alpha^J as J successive alpha shifts.
    always_comb begin
        scaled = syn_q;
        for (int unsigned k = 0; k < J; k++) begin
            scaled = {scaled[M-2:0], 1'b0} ^ (scaled[M-1] ? POLY : '0);
        end
    end

    always_comb begin
        syn_d = syn_q;
        if (start) begin
            syn_d = {{(M-1){1'b0}}, data_in};
        end else if (ce) begin
            syn_d = scaled ^ {{(M-1){1'b0}}, data_in};
        end
    end

    // No reset: the first accepted bit of every codeword asserts start.
    always_ff @(posedge clk) begin
        syn_q <= syn_d;
    end

    assign syn = syn_q;

endmodule

// File: rtl/bch_syndrome_stream.sv
// BCH syndrome front end: accepts a serial codeword (r_(N-1) first) under
// valid/ready, drives T Horner accumulators, and snapshots the syndromes into
// a held output register presented downstream under valid/ready.
// Ports: clk, reset (async, active-high); data_valid/data_ready/data_in bit
// stream in; syn_valid/syn_ready handshake out with syn_out (T fields of M
// bits, field i at [i*M +: M]) and syn_zero (all syndromes zero).
module bch_syndrome_stream
    import bch_syndrome_stream_pkg::*;
#(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           data_valid,
    output logic           data_ready,
    input  logic           data_in,
    output logic           syn_valid,
    input  logic           syn_ready,
    output logic [T*M-1:0] syn_out,
    output logic           syn_zero
);

    localparam int unsigned N     = (1 << M) - 1;
    localparam int unsigned CNT_W = clog2(N);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             syn_valid_q, syn_valid_d;
    logic [T*M-1:0]   syn_out_q, syn_out_d;
    logic             syn_zero_q, syn_zero_d;

    logic           out_free;
    logic           snap;
    logic           xfer;
    logic           acc_start;
    logic           acc_ce;
    logic [T*M-1:0] acc_flat;

    // Output register can take a new snapshot when empty or being drained now.
    assign out_free   = !syn_valid_q || syn_ready;
    assign snap       = (state_q == ST_FLUSH) && out_free;
    assign data_ready = (state_q == ST_RUN) || out_free;
    assign xfer       = data_valid && data_ready;
    assign acc_start  = xfer && (cnt_q == '0);
    assign acc_ce     = xfer && (cnt_q != '0);

    for (genvar gi = 0; gi < T; gi++) begin : g_acc
        bch_syndrome_stream_acc #(
            .M   (M),
            .IDX (gi)
        ) u_acc (
            .clk     (clk),
            .start   (acc_start),
            .ce      (acc_ce),
            .data_in (data_in),
            .syn     (acc_flat[gi*M +: M])
        );
    end

    // Next-state: bit counter, RUN/FLUSH control and output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        syn_valid_d = syn_valid_q;
        syn_out_d   = syn_out_q;
        syn_zero_d  = syn_zero_q;

        if (syn_valid_q && syn_ready) begin
            syn_valid_d = 1'b0;
        end

        // Snapshot samples pre-edge accumulator values, so a start in the same cycle is safe.
        if (snap) begin
            state_d     = ST_RUN;
            syn_valid_d = 1'b1;
            syn_out_d   = acc_flat;
            syn_zero_d  = (acc_flat == '0);
        end

        if (xfer) begin
            if (cnt_q == CNT_W'(N - 1)) begin
                cnt_d   = '0;
                state_d = ST_FLUSH;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            syn_valid_q <= 1'b0;
            syn_out_q   <= '0;
            syn_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            syn_valid_q <= syn_valid_d;
            syn_out_q   <= syn_out_d;
            syn_zero_q  <= syn_zero_d;
        end
    end

    assign syn_valid = syn_valid_q;
    assign syn_out   = syn_out_q;
    assign syn_zero  = syn_zero_q;

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Directed bench for bch_syndrome_stream at M=4, T=3 (x^4+x+1).
// Expected syndromes: r_0 error -> every field alpha^0 = 12'h111;
// r_1 error -> S1=alpha, S3=alpha^3, S5=alpha^5=alpha^2+alpha -> 12'h682.
module tb_bch_syndrome_stream;

    logic        clk;
    logic        reset;
    logic        data_valid;
    logic        data_ready;
    logic        data_in;
    logic        syn_valid;
    logic        syn_ready;
    logic [11:0] syn_out;
    logic        syn_zero;

    int checks;
    int errors;

    localparam logic [14:0] CW_ZERO = 15'h0000;
    localparam logic [14:0] CW_R0   = 15'h0001;
    localparam logic [14:0] CW_R1   = 15'h0002;

    bch_syndrome_stream #(
        .M (4),
        .T (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .syn_valid  (syn_valid),
        .syn_ready  (syn_ready),
        .syn_out    (syn_out),
        .syn_zero   (syn_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream one codeword, r_14 first; data_ready must stay high throughout.
    task automatic send_cw(input string tag, input logic [14:0] bits);
        for (int k = 14; k >= 0; k--) begin
            data_valid = 1'b1;
            data_in    = bits[k];
            check({tag, " data_ready"}, 32'(data_ready), 32'd1);
            tick();
        end
        data_valid = 1'b0;
        data_in    = 1'b0;
    endtask

    // After the last bit edge: one more edge to the snapshot, then check it.
    task automatic expect_result(input string tag, input logic [11:0] syn, input logic zero);
        check({tag, " valid_before"}, 32'(syn_valid), 32'd0);
        tick();
        check({tag, " syn_valid"}, 32'(syn_valid), 32'd1);
        check({tag, " syn_out"},   32'(syn_out),   32'(syn));
        check({tag, " syn_zero"},  32'(syn_zero),  32'(zero));
        tick();
        check({tag, " valid_clear"}, 32'(syn_valid), 32'd0);
    endtask

    initial begin
        logic [29:0] stream;
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 1'b0;
        syn_ready  = 1'b1;
        tick();
        tick();
        check("rst syn_valid",  32'(syn_valid),  32'd0);
        check("rst syn_out",    32'(syn_out),    32'd0);
        check("rst syn_zero",   32'(syn_zero),   32'd0);
        check("rst data_ready", 32'(data_ready), 32'd1);
        reset = 1'b0;
        tick();

        send_cw("zero", CW_ZERO);
        expect_result("zero", 12'h000, 1'b1);

        send_cw("r0", CW_R0);
        expect_result("r0", 12'h111, 1'b0);

        send_cw("r1", CW_R1);
        expect_result("r1", 12'h682, 1'b0);

        // Back-to-back: r_1 codeword then all-zero, no gap on the input.
        stream = {CW_R1, CW_ZERO};
        for (int i = 0; i < 30; i++) begin
            data_valid = 1'b1;
            data_in    = stream[29-i];
            check("b2b data_ready", 32'(data_ready), 32'd1);
            tick();
            if (i == 15) begin
                check("b2b first valid", 32'(syn_valid), 32'd1);
                check("b2b first out",   32'(syn_out),   32'h682);
                check("b2b first zero",  32'(syn_zero),  32'd0);
            end
            if (i == 16) check("b2b first clear", 32'(syn_valid), 32'd0);
        end
        data_valid = 1'b0;
        data_in    = 1'b0;
        expect_result("b2b second", 12'h000, 1'b1);

        // Backpressure: r_1 codeword then r_0 codeword with syn_ready low.
        syn_ready = 1'b0;
        stream    = {CW_R1, CW_R0};
        for (int i = 0; i < 30; i++) begin
            data_valid = 1'b1;
            data_in    = stream[29-i];
            check("bp data_ready", 32'(data_ready), 32'd1);
            tick();
        end
        // Offer another bit; it must not be accepted while stalled.
        data_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp stall ready", 32'(data_ready), 32'd0);
            check("bp hold valid",  32'(syn_valid),  32'd1);
            check("bp hold out",    32'(syn_out),    32'h682);
            tick();
        end
        data_valid = 1'b0;
        data_in    = 1'b0;
        syn_ready  = 1'b1;
        #1;
        check("bp release ready", 32'(data_ready), 32'd1);
        tick();
        syn_ready = 1'b0;
        #1;
        check("bp second valid", 32'(syn_valid),  32'd1);
        check("bp second out",   32'(syn_out),    32'h111);
        check("bp second zero",  32'(syn_zero),   32'd0);
        check("bp ready back",   32'(data_ready), 32'd1);
        syn_ready = 1'b1;
        tick();
        check("bp drained", 32'(syn_valid), 32'd0);

        // Reset mid-codeword: partial bits (all ones) must be discarded.
        for (int i = 0; i < 7; i++) begin
            data_valid = 1'b1;
            data_in    = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        data_in    = 1'b0;
        reset      = 1'b1;
        #1;
        check("mid rst valid", 32'(syn_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) begin
            data_valid = 1'b1;
            data_in    = 1'b0;
            tick();
            check("mid rst no valid", 32'(syn_valid), 32'd0);
        end
        data_valid = 1'b1;
        data_in    = 1'b0;
        tick();
        data_valid = 1'b0;
        expect_result("mid rst clean", 12'h000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
